sd_cmd_responder: RTL and testbench
===================================

# sd_cmd_responder

Card-side engine for the SD CMD line: the responder end of the host command path. Deserialises 48-bit host command frames, checks framing and CRC7, hands index and argument to card logic over a valid/ready pair, then serialises the card's response (48-bit R1/R3/R6/R7, optionally 136-bit R2) back onto CMD with CRC7 generated internally. Used as the synthesizable card model opposite the host SD controller in bench and loopback builds.

## Interface
- NCR, 2: minimum clocks from the command end-bit sample to the response start bit; legal range 2..63.
- iclk  in  1  SD clock (host CLK line); all logic on rising edge.
- irst_n  in  1  asynchronous active-low reset.
- icmd_sd  in  1  CMD line input, sampled on rising edge.
- ocmd_sd  out  1  CMD line output data, registered.
- ocmd_sd_en  out  1  CMD output enable, registered; high only while transmitting.
- ocmd_valid  out  1  one-cycle pulse: valid command received.
- ocmd_index  out  6  command index; held until next valid command.
- ocmd_arg  out  32  command argument; held until next valid command.
- ocrc_err  out  1  one-cycle pulse: frame rejected (CRC7 or end-bit error).
- oresp_ready  out  1  high while a response is accepted.
- iresp_valid  in  1  response handshake, taken when iresp_valid & oresp_ready.
- iresp_none  in  1  qualifies handshake: no response, return to idle.
- iresp_long  in  1  qualifies handshake: 136-bit R2.
- iresp_nocrc  in  1  qualifies handshake: CRC field sent as 7'h7F (R3).
- iresp_data  in  128  short: [37:0] = {index[5:0], content[31:0]}; long: [127:8] = CID/CSD payload.
- obusy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, RX, CHECK, WAIT_RESP, TX.
- IDLE: sampled icmd_sd=0 is the start bit -> RX; bit counter = 1.
- RX: shift 47 more bits MSB-first; running CRC7 (x^7+x^3+1) over bits 47..8. On the end-bit sample -> CHECK.
- CHECK (one cycle): transmission bit must be 1, otherwise silently discard -> IDLE (no pulse). CRC7 mismatch or end bit 0 -> ocrc_err pulse -> IDLE. Otherwise latch index/arg, pulse ocmd_valid -> WAIT_RESP.
- WAIT_RESP: oresp_ready=1. Handshake with iresp_none -> IDLE. A start bit sampled before any handshake abandons the command -> RX (host re-issued). Handshake qualifiers are sampled only in the handshake cycle.
- TX short: start 0, transmission 0, iresp_data[37:0], CRC7 over the preceding 40 bits (or 7'h7F if iresp_nocrc), end 1; 48 bits.
- TX long: start 0, transmission 0, 6'b111111, iresp_data[127:8], CRC7 over those 120 payload bits, end 1; 136 bits.
- After the end bit: ocmd_sd_en=0, ocmd_sd=1 -> IDLE. Received frames are ignored during TX.

## Timing
- Reset values: ocmd_sd=1, ocmd_sd_en=0, ocmd_valid=0, ocmd_index=0, ocmd_arg=0, ocrc_err=0, oresp_ready=0, obusy=0; state IDLE. Assertion releases CMD immediately (asynchronous), including mid-TX.
- Let E = edge sampling the command end bit. ocmd_valid/ocrc_err are high in the cycle after edge E+1; oresp_ready rises at edge E+1.
- Let R = edge at which the handshake is sampled. The start bit and ocmd_sd_en=1 appear at edge max(E+NCR, R+1); one bit per edge after that.
- Short response: ocmd_sd_en high for exactly 48 cycles; long: 136. It drops at the edge after the end bit.
- No timeout in WAIT_RESP; the host abandons by re-issuing a command.

## Configuration
- SD_RESP_R2_EN defined: long (136-bit) responses supported as above; TX bit counter 8 bits.
- Undefined: iresp_long ignored (treated as 0); iresp_data[127:38] unused; TX counter 6 bits; all responses are 48-bit.

## Test plan
- CMD8 frame 48'h48000001AA87 -> ocmd_valid, index 8, arg 32'h1AA; respond 38'h08000001AA with NCR=2 -> line carries 48'h08000001AA13, start bit at edge E+3 (R=E+2).
- CMD0 48'h400000000095, respond with iresp_none -> ocmd_valid, index 0; ocmd_sd_en never asserts; obusy falls the cycle after the handshake.
- CMD8 with CRC byte 8'h85 -> ocrc_err pulse, no ocmd_valid, no response; a following correct CMD8 is accepted.
- NCR=8, handshake at E+2 -> start bit at edge E+8; handshake at E+20 -> start bit at E+21.
- SD_RESP_R2_EN, CMD2, long response with payload 120'h1 -> 136 bits driven; CRC7 field matches the bench model; end bit 1.
- irst_n pulsed low mid-TX (bit 20) -> ocmd_sd_en=0 and ocmd_sd=1 without waiting for an edge; a subsequent CMD55 (48'h770000000065) gets ocmd_valid with index 55.

Source files
------------

// File: rtl/sd_cmd_responder.sv
// sd_cmd_responder: card-side SD CMD engine - receives 48-bit host commands, checks CRC7,
// hands index/argument to card logic and serialises the response. Define SD_RESP_R2_EN for 136-bit R2.
module sd_cmd_responder #(
  parameter int unsigned NCR = 2
) (
  input  logic         iclk,
  input  logic         irst_n,
  input  logic         icmd_sd,
  output logic         ocmd_sd,
  output logic         ocmd_sd_en,
  output logic         ocmd_valid,
  output logic [5:0]   ocmd_index,
  output logic [31:0]  ocmd_arg,
  output logic         ocrc_err,
  output logic         oresp_ready,
  input  logic         iresp_valid,
  input  logic         iresp_none,
  input  logic         iresp_long,
  input  logic         iresp_nocrc,
  input  logic [127:0] iresp_data,
  output logic         obusy
);

`ifdef SD_RESP_R2_EN
  localparam int unsigned TXW = 8;
  localparam int unsigned SRW = 128;
`else
  localparam int unsigned TXW = 6;
  localparam int unsigned SRW = 40;
`endif
  localparam logic [5:0] NCR_M1 = 6'(NCR - 1);

  typedef enum logic [2:0] {IDLE, RX, CHECK, WAIT_RESP, TX} state_t;
  state_t state;

  logic [46:0]    rx_sr;
  logic [5:0]     rx_cnt;
  logic [6:0]     crc_q;
  logic [5:0]     ncr_cnt;
  logic [SRW-1:0] tx_sr;
  logic [TXW-1:0] tx_cnt;
  logic           tx_nocrc;
  logic [TXW-1:0] crc_lo, crc_pos, crc_end, tx_len;

`ifdef SD_RESP_R2_EN
  logic tx_long;
  logic unused_lsb;
  assign unused_lsb = ^iresp_data[7:0];
`else
  logic unused_in;
  assign unused_in = ^{iresp_long, iresp_data[127:38]};
`endif

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  always_comb begin
    crc_lo  = '0;
    crc_pos = TXW'(40);
    crc_end = TXW'(47);
    tx_len  = TXW'(48);
`ifdef SD_RESP_R2_EN
    if (tx_long) begin
      crc_lo  = TXW'(8);
      crc_pos = TXW'(128);
      crc_end = TXW'(135);
      tx_len  = TXW'(136);
    end
`endif
  end

  assign obusy = (state != IDLE);

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state       <= IDLE;
      ocmd_sd     <= 1'b1;
      ocmd_sd_en  <= 1'b0;
      ocmd_valid  <= 1'b0;
      ocmd_index  <= '0;
      ocmd_arg    <= '0;
      ocrc_err    <= 1'b0;
      oresp_ready <= 1'b0;
      rx_sr       <= '0;
      rx_cnt      <= '0;
      crc_q       <= '0;
      ncr_cnt     <= '0;
      tx_sr       <= '0;
      tx_cnt      <= '0;
      tx_nocrc    <= 1'b0;
`ifdef SD_RESP_R2_EN
      tx_long     <= 1'b0;
`endif
    end else begin
      ocmd_valid <= 1'b0;
      ocrc_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!icmd_sd) begin
            state  <= RX;
            rx_cnt <= 6'd1;
            rx_sr  <= '0;
            crc_q  <= '0;
          end
        end
        RX: begin
          rx_sr <= {rx_sr[45:0], icmd_sd};
          if (rx_cnt < 6'd40) crc_q <= crc7_step(crc_q, icmd_sd);
          if (rx_cnt == 6'd47) state <= CHECK;
          else rx_cnt <= rx_cnt + 6'd1;
        end
        CHECK: begin
          if (!rx_sr[46]) begin
            state <= IDLE;
          end else if ((rx_sr[7:1] != crc_q) || !rx_sr[0]) begin
            ocrc_err <= 1'b1;
            state    <= IDLE;
          end else begin
            ocmd_index  <= rx_sr[45:40];
            ocmd_arg    <= rx_sr[39:8];
            ocmd_valid  <= 1'b1;
            oresp_ready <= 1'b1;
            ncr_cnt     <= 6'd1;
            state       <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (ncr_cnt != 6'h3F) ncr_cnt <= ncr_cnt + 6'd1;
          if (iresp_valid) begin
            oresp_ready <= 1'b0;
            if (iresp_none) begin
              state <= IDLE;
            end else begin
              state    <= TX;
              tx_cnt   <= '0;
              crc_q    <= '0;
              tx_nocrc <= iresp_nocrc;
`ifdef SD_RESP_R2_EN
              tx_long <= iresp_long;
              if (iresp_long) tx_sr <= {2'b00, 6'h3F, iresp_data[127:8]};
              else            tx_sr <= {2'b00, iresp_data[37:0], 88'b0};
`else
              tx_sr <= {2'b00, iresp_data[37:0]};
`endif
            end
          end else if (!icmd_sd) begin
            oresp_ready <= 1'b0;
            state       <= RX;
            rx_cnt      <= 6'd1;
            rx_sr       <= '0;
            crc_q       <= '0;
          end
        end
        TX: begin
          if (ncr_cnt != 6'h3F) ncr_cnt <= ncr_cnt + 6'd1;
          // ncr_cnt holds (edge - E - 1); the start bit waits until edge E+NCR
          if ((tx_cnt != '0) || (ncr_cnt >= NCR_M1)) begin
            if (tx_cnt == tx_len) begin
              ocmd_sd_en <= 1'b0;
              ocmd_sd    <= 1'b1;
              state      <= IDLE;
            end else begin
              ocmd_sd_en <= 1'b1;
              tx_cnt     <= tx_cnt + TXW'(1);
              if (tx_cnt < crc_pos) begin
                ocmd_sd <= tx_sr[SRW-1];
                tx_sr   <= {tx_sr[SRW-2:0], 1'b0};
                if (tx_cnt >= crc_lo) crc_q <= crc7_step(crc_q, tx_sr[SRW-1]);
              end else if (tx_cnt < crc_end) begin
                ocmd_sd <= tx_nocrc | crc_q[6];
                crc_q   <= {crc_q[5:0], 1'b0};
              end else begin
                ocmd_sd <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Directed bench for sd_cmd_responder: two instances (NCR=2 and NCR=8) driven on separate CMD lines.
module tb_sd_cmd_responder;
  logic         iclk = 1'b0;
  logic         irst_n;
  logic         icmd_sd, icmd8;
  logic         iresp_valid, iresp_valid8, iresp_none, iresp_long, iresp_nocrc;
  logic [127:0] iresp_data;
  logic         ocmd_sd, ocmd_sd_en, ocmd_valid, ocrc_err, oresp_ready, obusy;
  logic [5:0]   ocmd_index;
  logic [31:0]  ocmd_arg;
  logic         o8_sd, o8_en, o8_valid, o8_crc_err, o8_ready, o8_busy;
  logic [5:0]   o8_index;
  logic [31:0]  o8_arg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc <= cyc + 1;

  sd_cmd_responder #(.NCR(2)) dut (
    .iclk(iclk), .irst_n(irst_n), .icmd_sd(icmd_sd),
    .ocmd_sd(ocmd_sd), .ocmd_sd_en(ocmd_sd_en), .ocmd_valid(ocmd_valid),
    .ocmd_index(ocmd_index), .ocmd_arg(ocmd_arg), .ocrc_err(ocrc_err),
    .oresp_ready(oresp_ready), .iresp_valid(iresp_valid), .iresp_none(iresp_none),
    .iresp_long(iresp_long), .iresp_nocrc(iresp_nocrc), .iresp_data(iresp_data),
    .obusy(obusy)
  );

  sd_cmd_responder #(.NCR(8)) dut8 (
    .iclk(iclk), .irst_n(irst_n), .icmd_sd(icmd8),
    .ocmd_sd(o8_sd), .ocmd_sd_en(o8_en), .ocmd_valid(o8_valid),
    .ocmd_index(o8_index), .ocmd_arg(o8_arg), .ocrc_err(o8_crc_err),
    .oresp_ready(o8_ready), .iresp_valid(iresp_valid8), .iresp_none(iresp_none),
    .iresp_long(iresp_long), .iresp_nocrc(iresp_nocrc), .iresp_data(iresp_data),
    .obusy(o8_busy)
  );

  // Polynomial-division form of CRC7 (x^7 + x^3 + 1) over the low n bits of v, MSB first.
  function automatic logic [6:0] crc7_model(input logic [127:0] v, input int n);
    logic [6:0] c;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      logic fb;
      fb = c[6] ^ v[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic send_frame(input logic [47:0] f, input bit sel8, output int e);
    for (int i = 47; i >= 0; i--) begin
      @(negedge iclk);
      if (sel8) icmd8 = f[i]; else icmd_sd = f[i];
    end
    @(posedge iclk); #1;
    e = cyc;
    icmd_sd = 1'b1;
    icmd8   = 1'b1;
  endtask

  task automatic respond(input bit sel8, input bit none, input bit lng, input logic [127:0] data);
    iresp_none = none;
    iresp_long = lng;
    iresp_data = data;
    if (sel8) iresp_valid8 = 1'b1; else iresp_valid = 1'b1;
    @(posedge iclk); #1;
    iresp_valid  = 1'b0;
    iresp_valid8 = 1'b0;
    iresp_none   = 1'b0;
    iresp_long   = 1'b0;
  endtask

  task automatic capture(input bit sel8, input int nbits, output logic [135:0] bits,
                         output int t_start, output int en_cycles);
    bits = '0;
    t_start = -1;
    en_cycles = 0;
    for (int k = 0; k < 200 && t_start < 0; k++) begin
      @(posedge iclk); #1;
      if (sel8 ? o8_en : ocmd_sd_en) t_start = cyc;
    end
    if (t_start >= 0) begin
      for (int i = 0; i < nbits; i++) begin
        if (i > 0) begin @(posedge iclk); #1; end
        bits = {bits[134:0], sel8 ? o8_sd : ocmd_sd};
        if (sel8 ? o8_en : ocmd_sd_en) en_cycles++;
      end
      @(posedge iclk); #1;
      if (sel8 ? o8_en : ocmd_sd_en) en_cycles++;
    end
  endtask

  task automatic test_reset;
    irst_n = 1'b0;
    icmd_sd = 1'b1; icmd8 = 1'b1;
    iresp_valid = 1'b0; iresp_valid8 = 1'b0; iresp_none = 1'b0;
    iresp_long = 1'b0; iresp_nocrc = 1'b0; iresp_data = '0;
    repeat (3) @(posedge iclk);
    #1;
    checks++;
    if ({ocmd_sd, ocmd_sd_en, ocmd_valid, ocrc_err, oresp_ready, obusy, ocmd_index, ocmd_arg} !== {6'b100000, 38'h0}) begin
      errors++;
      $display("FAIL reset_outputs: got %b_%h_%h expected 100000_00_00000000",
               {ocmd_sd, ocmd_sd_en, ocmd_valid, ocrc_err, oresp_ready, obusy}, ocmd_index, ocmd_arg);
    end
    checks++;
    if ({o8_sd, o8_en, o8_valid, o8_busy} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_outputs_ncr8: got %b expected 1000", {o8_sd, o8_en, o8_valid, o8_busy});
    end
    @(negedge iclk);
    irst_n = 1'b1;
    repeat (2) @(posedge iclk);
  endtask

  task automatic test_cmd8_short;
    int e, t, en_n;
    logic [135:0] bits;
    send_frame(48'h48000001AA87, 1'b0, e);
    @(posedge iclk); #1;
    checks++;
    if ({ocmd_valid, oresp_ready, ocmd_index, ocmd_arg} !== {2'b11, 6'd8, 32'h1AA}) begin
      errors++;
      $display("FAIL cmd8_accept: got v=%b r=%b idx=%0d arg=%h expected v=1 r=1 idx=8 arg=000001aa",
               ocmd_valid, oresp_ready, ocmd_index, ocmd_arg);
    end
    respond(1'b0, 1'b0, 1'b0, 128'h08000001AA);
    checks++;
    if (oresp_ready !== 1'b0) begin
      errors++;
      $display("FAIL cmd8_ready_drop: got %b expected 0", oresp_ready);
    end
    capture(1'b0, 48, bits, t, en_n);
    checks++;
    if (t - e !== 3) begin
      errors++;
      $display("FAIL cmd8_start_edge: got E+%0d expected E+3", t - e);
    end
    checks++;
    if (bits[47:0] !== 48'h08000001AA13) begin
      errors++;
      $display("FAIL cmd8_resp_bits: got %h expected 08000001aa13", bits[47:0]);
    end
    checks++;
    if (en_n !== 48) begin
      errors++;
      $display("FAIL cmd8_en_cycles: got %0d expected 48", en_n);
    end
    checks++;
    if ({ocmd_sd, ocmd_sd_en, obusy} !== 3'b100) begin
      errors++;
      $display("FAIL cmd8_release: got %b expected 100", {ocmd_sd, ocmd_sd_en, obusy});
    end
  endtask

  task automatic test_cmd0_none;
    int e;
    bit seen_en;
    send_frame(48'h400000000095, 1'b0, e);
    @(posedge iclk); #1;
    checks++;
    if ({ocmd_valid, ocmd_index} !== {1'b1, 6'd0}) begin
      errors++;
      $display("FAIL cmd0_accept: got v=%b idx=%0d expected v=1 idx=0", ocmd_valid, ocmd_index);
    end
    respond(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if ({obusy, oresp_ready} !== 2'b00) begin
      errors++;
      $display("FAIL cmd0_idle_after_hs: got busy/ready=%b expected 00", {obusy, oresp_ready});
    end
    seen_en = 1'b0;
    repeat (12) begin
      @(posedge iclk); #1;
      if (ocmd_sd_en) seen_en = 1'b1;
    end
    checks++;
    if (seen_en !== 1'b0) begin
      errors++;
      $display("FAIL cmd0_no_tx: got en seen=%b expected 0", seen_en);
    end
  endtask

  task automatic test_bad_crc;
    int e;
    send_frame(48'h48000001AA85, 1'b0, e);
    @(posedge iclk); #1;
    checks++;
    if ({ocrc_err, ocmd_valid, oresp_ready, obusy} !== 4'b1000) begin
      errors++;
      $display("FAIL badcrc_pulse: got err/v/r/busy=%b expected 1000",
               {ocrc_err, ocmd_valid, oresp_ready, obusy});
    end
    @(posedge iclk); #1;
    checks++;
    if (ocrc_err !== 1'b0) begin
      errors++;
      $display("FAIL badcrc_one_cycle: got %b expected 0", ocrc_err);
    end
    send_frame(48'h48000001AA87, 1'b0, e);
    @(posedge iclk); #1;
    checks++;
    if ({ocmd_valid, ocrc_err, ocmd_index} !== {2'b10, 6'd8}) begin
      errors++;
      $display("FAIL badcrc_recover: got v=%b err=%b idx=%0d expected v=1 err=0 idx=8",
               ocmd_valid, ocrc_err, ocmd_index);
    end
    respond(1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic test_trans_discard;
    int e;
    send_frame(48'h08000001AA87, 1'b0, e);
    @(posedge iclk); #1;
    checks++;
    if ({ocrc_err, ocmd_valid, oresp_ready, obusy} !== 4'b0000) begin
      errors++;
      $display("FAIL trans_bit_discard: got err/v/r/busy=%b expected 0000",
               {ocrc_err, ocmd_valid, oresp_ready, obusy});
    end
  endtask

  task automatic test_abandon;
    int e;
    send_frame(48'h48000001AA87, 1'b0, e);
    @(posedge iclk); #1;
    send_frame(48'h770000000065, 1'b0, e);
    @(posedge iclk); #1;
    checks++;
    if ({ocmd_valid, ocmd_index, ocmd_arg} !== {1'b1, 6'd55, 32'h0}) begin
      errors++;
      $display("FAIL abandon_reissue: got v=%b idx=%0d arg=%h expected v=1 idx=55 arg=00000000",
               ocmd_valid, ocmd_index, ocmd_arg);
    end
    respond(1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic test_ncr;
    int e, t, en_n;
    logic [135:0] bits;
    send_frame(48'h48000001AA87, 1'b1, e);
    @(posedge iclk); #1;
    checks++;
    if ({o8_valid, o8_index, o8_arg} !== {1'b1, 6'd8, 32'h1AA}) begin
      errors++;
      $display("FAIL ncr8_accept: got v=%b idx=%0d arg=%h expected v=1 idx=8 arg=000001aa",
               o8_valid, o8_index, o8_arg);
    end
    respond(1'b1, 1'b0, 1'b0, 128'h08000001AA);
    capture(1'b1, 48, bits, t, en_n);
    checks++;
    if (t - e !== 8) begin
      errors++;
      $display("FAIL ncr8_early_hs_start: got E+%0d expected E+8", t - e);
    end
    checks++;
    if ({bits[47:0], en_n[7:0]} !== {48'h08000001AA13, 8'd48}) begin
      errors++;
      $display("FAIL ncr8_resp: got %h/%0d expected 08000001aa13/48", bits[47:0], en_n);
    end
    send_frame(48'h48000001AA87, 1'b1, e);
    repeat (19) begin @(posedge iclk); #1; end
    checks++;
    if (o8_ready !== 1'b1) begin
      errors++;
      $display("FAIL ncr8_ready_held: got %b expected 1", o8_ready);
    end
    respond(1'b1, 1'b0, 1'b0, 128'h08000001AA);
    capture(1'b1, 48, bits, t, en_n);
    checks++;
    if (t - e !== 21) begin
      errors++;
      $display("FAIL ncr8_late_hs_start: got E+%0d expected E+21", t - e);
    end
  endtask

`ifdef SD_RESP_R2_EN
  task automatic test_long;
    int e, t, en_n;
    logic [135:0] bits, exp_bits;
    logic [127:0] cmd_body;
    logic [6:0]   exp_crc;
    cmd_body = {88'h0, 2'b01, 6'd2, 32'h0};
    send_frame({cmd_body[39:0], crc7_model(cmd_body, 40), 1'b1}, 1'b0, e);
    @(posedge iclk); #1;
    checks++;
    if ({ocmd_valid, ocmd_index} !== {1'b1, 6'd2}) begin
      errors++;
      $display("FAIL r2_cmd2_accept: got v=%b idx=%0d expected v=1 idx=2", ocmd_valid, ocmd_index);
    end
    respond(1'b0, 1'b0, 1'b1, {120'h1, 8'h00});
    capture(1'b0, 136, bits, t, en_n);
    exp_crc  = crc7_model(128'h1, 120);
    exp_bits = {2'b00, 6'h3F, 120'h1, exp_crc, 1'b1};
    checks++;
    if (bits[7:0] !== {exp_crc, 1'b1}) begin
      errors++;
      $display("FAIL r2_crc_end: got %h expected %h", bits[7:0], {exp_crc, 1'b1});
    end
    checks++;
    if (bits !== exp_bits) begin
      errors++;
      $display("FAIL r2_bits: got %h expected %h", bits, exp_bits);
    end
    checks++;
    if ({en_n, t - e} !== {136, 3}) begin
      errors++;
      $display("FAIL r2_timing: got en=%0d start=E+%0d expected en=136 start=E+3", en_n, t - e);
    end
  endtask
`endif

  task automatic test_reset_mid_tx;
    int e;
    bit started;
    send_frame(48'h48000001AA87, 1'b0, e);
    @(posedge iclk); #1;
    respond(1'b0, 1'b0, 1'b0, 128'h08000001AA);
    started = 1'b0;
    for (int k = 0; k < 50 && !started; k++) begin
      @(posedge iclk); #1;
      if (ocmd_sd_en) started = 1'b1;
    end
    checks++;
    if (started !== 1'b1) begin
      errors++;
      $display("FAIL midtx_started: got %b expected 1", started);
    end
    repeat (20) @(posedge iclk);
    #3;
    irst_n = 1'b0;
    #1;
    checks++;
    if ({ocmd_sd_en, ocmd_sd, obusy} !== 3'b010) begin
      errors++;
      $display("FAIL midtx_async_release: got en/sd/busy=%b expected 010", {ocmd_sd_en, ocmd_sd, obusy});
    end
    repeat (2) @(posedge iclk);
    @(negedge iclk);
    irst_n = 1'b1;
    send_frame(48'h770000000065, 1'b0, e);
    @(posedge iclk); #1;
    checks++;
    if ({ocmd_valid, ocmd_index} !== {1'b1, 6'd55}) begin
      errors++;
      $display("FAIL midtx_cmd55: got v=%b idx=%0d expected v=1 idx=55", ocmd_valid, ocmd_index);
    end
    respond(1'b0, 1'b1, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_cmd8_short();
    test_cmd0_none();
    test_bad_crc();
    test_trans_discard();
    test_abandon();
    test_ncr();
`ifdef SD_RESP_R2_EN
    test_long();
`endif
    test_reset_mid_tx();
    repeat (2) @(posedge iclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
